// File: rtl/gt_victim_cache.sv
// gt_victim_cache
//   Fully-associative victim cache that sits between the L1 data cache and
//   the memory interface. L1 evictions are inserted. Later L1 misses look
//   the line up, and a hit returns the line and removes it from the cache.
//   When tree-PLRU replacement displaces a dirty line, or a flush drains
//   one, the line leaves through a single-entry valid/ready writeback
//   register.
//
// Ports
//   CLK, RST_N                 clock (rising edge), async active-low reset
//   lookup_valid/lookup_addr   lookup request
//   resp_valid/hit/data/byte/dirty
//                              registered response, one cycle after the request
//   insert_valid/ready/addr/data/dirty
//                              L1 eviction handshake
//   wb_valid/ready/addr/data   writeback handshake to memory
//   flush_req/flush_busy       write back all dirty lines, then invalidate all
module gt_victim_cache #(
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32,
    parameter int WAYS      = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 lookup_valid,
    input  logic [ADDR_W-1:0]    lookup_addr,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [LINE_BITS-1:0] resp_data,
    output logic [7:0]           resp_byte,
    output logic                 resp_dirty,
    input  logic                 insert_valid,
    output logic                 insert_ready,
    input  logic [ADDR_W-1:0]    insert_addr,
    input  logic [LINE_BITS-1:0] insert_data,
    input  logic                 insert_dirty,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [ADDR_W-1:0]    wb_addr,
    output logic [LINE_BITS-1:0] wb_data,
    input  logic                 flush_req,
    output logic                 flush_busy
);

    localparam int OFF_W = $clog2(LINE_BITS / 8);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int IDX_W = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT} stateT;

    stateT                stateQ, stateD;
    logic [IDX_W-1:0]     scanIdxQ, scanIdxD;
    logic                 scanLoad, scanClear;

    logic [WAYS-1:0]      validQ, dirtyQ;
    logic [TAG_W-1:0]     tagQ  [WAYS];
    logic [LINE_BITS-1:0] dataQ [WAYS];
    // Tree nodes 0..WAYS-2 in heap order (children of n are 2n+1, 2n+2).
    // The top bit is never written; it pads the vector to WAYS bits so a
    // node index is exactly IDX_W bits wide.
    logic [WAYS-1:0]      plruQ, plruUpd;

    logic [TAG_W-1:0]     lookTag, insTag;
    logic [OFF_W-1:0]     lookOff;
    logic                 lookHit, lookAct;
    logic [IDX_W-1:0]     lookWay;
    logic                 insMatch, insFree, insFire, insEvict;
    logic [IDX_W-1:0]     insMatchWay, insFreeWay, insWay, victimWay;
    logic [IDX_W-1:0]     vicNode, updNode;
    logic                 unusedOffset;

    assign lookTag      = lookup_addr[ADDR_W-1:OFF_W];
    assign lookOff      = lookup_addr[OFF_W-1:0];
    assign insTag       = insert_addr[ADDR_W-1:OFF_W];
    assign unusedOffset = ^insert_addr[OFF_W-1:0];

    assign flush_busy   = (stateQ != IDLE);
    assign insert_ready = !wb_valid && (stateQ == IDLE);
    assign insFire      = insert_valid && insert_ready;
    // Lookups are answered during a flush, but they always miss there.
    assign lookAct      = lookup_valid && lookHit && (stateQ == IDLE);

    always_comb begin
        lookHit = 1'b0;
        lookWay = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!lookHit && validQ[w] && (tagQ[w] == lookTag)) begin
                lookHit = 1'b1;
                lookWay = IDX_W'(w);
            end
        end
    end

    always_comb begin
        insMatch    = 1'b0;
        insMatchWay = '0;
        insFree     = 1'b0;
        insFreeWay  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!insMatch && validQ[w] && (tagQ[w] == insTag)) begin
                insMatch    = 1'b1;
                insMatchWay = IDX_W'(w);
            end
            if (!insFree && !validQ[w]) begin
                insFree    = 1'b1;
                insFreeWay = IDX_W'(w);
            end
        end
    end

    // Follow the tree from the root. Each node bit selects the subtree that
    // holds the victim: 0 means the left subtree, 1 means the right one.
    always_comb begin
        victimWay = '0;
        vicNode   = '0;
        for (int unsigned l = 0; l < IDX_W; l++) begin
            victimWay[IDX_W-1-l] = plruQ[vicNode];
            vicNode = (vicNode << 1) + (plruQ[vicNode] ? IDX_W'(2) : IDX_W'(1));
        end
    end

    always_comb begin
        if (insMatch)
            insWay = insMatchWay;
        else if (insFree)
            insWay = insFreeWay;
        else
            insWay = victimWay;
        insEvict = !insMatch && !insFree && dirtyQ[victimWay];
    end

    // Every node on the path to the written way is set to point away from it.
    always_comb begin
        plruUpd = plruQ;
        updNode = '0;
        for (int unsigned l = 0; l < IDX_W; l++) begin
            plruUpd[updNode] = !insWay[IDX_W-1-l];
            updNode = (updNode << 1) + (insWay[IDX_W-1-l] ? IDX_W'(2) : IDX_W'(1));
        end
    end

    // Flush sequencer. When SCAN loads a dirty way, it also clears that way's
    // dirty bit. After WAIT, SCAN revisits the same way, finds it clean and
    // moves on to the next index.
    always_comb begin
        stateD    = stateQ;
        scanIdxD  = scanIdxQ;
        scanLoad  = 1'b0;
        scanClear = 1'b0;
        case (stateQ)
            IDLE: begin
                if (flush_req) begin
                    stateD   = SCAN;
                    scanIdxD = '0;
                end
            end
            SCAN: begin
                if (!wb_valid) begin
                    if (validQ[scanIdxQ] && dirtyQ[scanIdxQ]) begin
                        scanLoad = 1'b1;
                        stateD   = WAIT;
                    end else if (scanIdxQ == IDX_W'(WAYS - 1)) begin
                        scanClear = 1'b1;
                        stateD    = IDLE;
                    end else begin
                        scanIdxD = scanIdxQ + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wb_valid && wb_ready)
                    stateD = SCAN;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stateQ     <= IDLE;
            scanIdxQ   <= '0;
            validQ     <= '0;
            dirtyQ     <= '0;
            plruQ      <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_data  <= '0;
            resp_byte  <= '0;
            resp_dirty <= 1'b0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
        end else begin
            stateQ   <= stateD;
            scanIdxQ <= scanIdxD;

            resp_valid <= lookup_valid;
            resp_hit   <= lookAct;
            resp_data  <= lookAct ? dataQ[lookWay] : '0;
            resp_byte  <= lookAct ? dataQ[lookWay][{lookOff, 3'b000} +: 8] : 8'h00;
            resp_dirty <= lookAct && dirtyQ[lookWay];

            if (lookAct) begin
                validQ[lookWay] <= 1'b0;
                dirtyQ[lookWay] <= 1'b0;
            end

            if (wb_valid && wb_ready)
                wb_valid <= 1'b0;

            // Placed after the lookup invalidation, so an insert to the same
            // way in the same cycle wins.
            if (insFire) begin
                validQ[insWay] <= 1'b1;
                dirtyQ[insWay] <= insert_dirty || (insMatch && dirtyQ[insWay]);
                plruQ          <= plruUpd;
                if (insEvict) begin
                    wb_valid <= 1'b1;
                    wb_addr  <= {tagQ[victimWay], {OFF_W{1'b0}}};
                    wb_data  <= dataQ[victimWay];
                end
            end

            if (scanLoad) begin
                wb_valid         <= 1'b1;
                wb_addr          <= {tagQ[scanIdxQ], {OFF_W{1'b0}}};
                wb_data          <= dataQ[scanIdxQ];
                dirtyQ[scanIdxQ] <= 1'b0;
            end

            if (scanClear) begin
                validQ <= '0;
                dirtyQ <= '0;
                plruQ  <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (insFire) begin
            tagQ[insWay]  <= insTag;
            dataQ[insWay] <= insert_data;
        end
    end

endmodule

// File: tb/tb_gt_victim_cache.sv
module tb_gt_victim_cache;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         lookup_valid = 1'b0;
    logic [31:0]  lookup_addr = '0;
    logic         resp_valid, resp_hit, resp_dirty;
    logic [255:0] resp_data;
    logic [7:0]   resp_byte;
    logic         insert_valid = 1'b0;
    logic         insert_ready;
    logic [31:0]  insert_addr = '0;
    logic [255:0] insert_data = '0;
    logic         insert_dirty = 1'b0;
    logic         wb_valid;
    logic         wb_ready = 1'b0;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    logic         flush_req = 1'b0;
    logic         flush_busy;

    int nChecks = 0;
    int nFails  = 0;

    gt_victim_cache #(.LINE_BITS(256), .ADDR_W(32), .WAYS(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
        .resp_byte(resp_byte), .resp_dirty(resp_dirty),
        .insert_valid(insert_valid), .insert_ready(insert_ready),
        .insert_addr(insert_addr), .insert_data(insert_data), .insert_dirty(insert_dirty),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush_req(flush_req), .flush_busy(flush_busy)
    );

    always #5 CLK = ~CLK;

    task automatic checkEq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte i of a test line is seed + 7*i.
    function automatic logic [255:0] mkLine(input logic [7:0] s);
        logic [255:0] l;
        for (int i = 0; i < 32; i++)
            l[8*i +: 8] = s + 8'(i * 7);
        return l;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic applyReset;
        RST_N        = 1'b0;
        lookup_valid = 1'b0;
        insert_valid = 1'b0;
        flush_req    = 1'b0;
        wb_ready     = 1'b0;
        tick;
        tick;
        RST_N = 1'b1;
        tick;
    endtask

    task automatic doInsert(input logic [31:0] a, input logic [255:0] d, input logic dty);
        int n;
        insert_valid = 1'b1;
        insert_addr  = a;
        insert_data  = d;
        insert_dirty = dty;
        n = 0;
        while (!insert_ready && n < 50) begin
            tick;
            n++;
        end
        if (n == 50)
            checkEq("insert_ready_timeout", {255'b0, insert_ready}, 256'd1);
        tick;
        insert_valid = 1'b0;
    endtask

    task automatic doLookup(input string tag, input logic [31:0] a, input logic expHit,
                            input logic expDirty, input logic [7:0] expByte,
                            input logic [255:0] expData);
        lookup_valid = 1'b1;
        lookup_addr  = a;
        tick;
        lookup_valid = 1'b0;
        checkEq({tag, "_valid"}, {255'b0, resp_valid}, 256'd1);
        checkEq({tag, "_hit"}, {255'b0, resp_hit}, {255'b0, expHit});
        checkEq({tag, "_byte"}, {248'b0, resp_byte}, {248'b0, expByte});
        checkEq({tag, "_data"}, resp_data, expData);
        if (expHit)
            checkEq({tag, "_dirty"}, {255'b0, resp_dirty}, {255'b0, expDirty});
    endtask

    initial begin
        int nWb;
        logic [31:0]  wbA [3];
        logic [255:0] wbD [3];

        // Reset values
        applyReset;
        checkEq("rst_insert_ready", {255'b0, insert_ready}, 256'd1);
        checkEq("rst_resp_valid", {255'b0, resp_valid}, 256'd0);
        checkEq("rst_wb_valid", {255'b0, wb_valid}, 256'd0);
        checkEq("rst_wb_addr", {224'b0, wb_addr}, 256'd0);
        checkEq("rst_wb_data", wb_data, 256'd0);
        checkEq("rst_flush_busy", {255'b0, flush_busy}, 256'd0);

        // Basic hit with byte select, then swap-out
        doInsert(32'h1000, mkLine(8'h10), 1'b0);
        doInsert(32'h2000, mkLine(8'h20), 1'b0);
        doInsert(32'h3000, mkLine(8'h30), 1'b0);
        doInsert(32'h4000, mkLine(8'h40), 1'b0);
        doLookup("hit2005", 32'h2005, 1'b1, 1'b0, 8'h43, mkLine(8'h20));
        tick;
        checkEq("resp_valid_drop", {255'b0, resp_valid}, 256'd0);
        doLookup("miss2005", 32'h2005, 1'b0, 1'b0, 8'h00, 256'd0);

        // PLRU eviction with a stalled writeback
        applyReset;
        doInsert(32'h1000, mkLine(8'h51), 1'b1);
        doInsert(32'h2000, mkLine(8'h52), 1'b1);
        doInsert(32'h3000, mkLine(8'h53), 1'b1);
        doInsert(32'h4000, mkLine(8'h54), 1'b1);
        doInsert(32'h5000, mkLine(8'h55), 1'b0);
        checkEq("evict_wb_valid", {255'b0, wb_valid}, 256'd1);
        checkEq("evict_wb_addr", {224'b0, wb_addr}, 256'h1000);
        checkEq("evict_wb_data", wb_data, mkLine(8'h51));
        checkEq("evict_ins_ready", {255'b0, insert_ready}, 256'd0);
        tick;
        tick;
        checkEq("stall_wb_valid", {255'b0, wb_valid}, 256'd1);
        checkEq("stall_wb_addr", {224'b0, wb_addr}, 256'h1000);
        checkEq("stall_ins_ready", {255'b0, insert_ready}, 256'd0);
        wb_ready = 1'b1;
        tick;
        wb_ready = 1'b0;
        checkEq("accept_wb_valid", {255'b0, wb_valid}, 256'd0);
        checkEq("accept_ins_ready", {255'b0, insert_ready}, 256'd1);
        doLookup("evicted1000", 32'h1000, 1'b0, 1'b0, 8'h00, 256'd0);

        // Invalid way preferred over PLRU victim (which would be dirty way 2)
        doLookup("hit2010", 32'h2010, 1'b1, 1'b1, 8'hC2, mkLine(8'h52));
        doInsert(32'h6000, mkLine(8'h56), 1'b0);
        checkEq("free_way_no_wb", {255'b0, wb_valid}, 256'd0);
        wb_ready = 1'b1;
        doInsert(32'h7000, mkLine(8'h57), 1'b1);
        checkEq("evict2_wb_valid", {255'b0, wb_valid}, 256'd1);
        checkEq("evict2_wb_addr", {224'b0, wb_addr}, 256'h3000);
        checkEq("evict2_wb_data", wb_data, mkLine(8'h53));
        tick;
        checkEq("evict2_wb_drop", {255'b0, wb_valid}, 256'd0);
        wb_ready = 1'b0;
        doLookup("hit6000", 32'h6000, 1'b1, 1'b0, 8'h56, mkLine(8'h56));
        doLookup("hit5000", 32'h5000, 1'b1, 1'b0, 8'h55, mkLine(8'h55));
        doLookup("hit401f", 32'h401F, 1'b1, 1'b1, 8'h2D, mkLine(8'h54));
        doLookup("hit7001", 32'h7001, 1'b1, 1'b1, 8'h5E, mkLine(8'h57));
        doLookup("miss3000", 32'h3000, 1'b0, 1'b0, 8'h00, 256'd0);

        // Same-tag overwrite keeps one entry and ORs the dirty flags
        applyReset;
        doInsert(32'h1000, mkLine(8'h71), 1'b0);
        doInsert(32'h1000, mkLine(8'h72), 1'b1);
        checkEq("overwrite_no_wb", {255'b0, wb_valid}, 256'd0);
        doLookup("overwrite_hit", 32'h1000, 1'b1, 1'b1, 8'h72, mkLine(8'h72));
        doLookup("overwrite_gone", 32'h1000, 1'b0, 1'b0, 8'h00, 256'd0);

        // Same-cycle lookup and insert of one line: old contents, insert wins
        applyReset;
        doInsert(32'h1000, mkLine(8'h61), 1'b0);
        lookup_valid = 1'b1;
        lookup_addr  = 32'h1000;
        insert_valid = 1'b1;
        insert_addr  = 32'h1000;
        insert_data  = mkLine(8'h62);
        insert_dirty = 1'b1;
        tick;
        lookup_valid = 1'b0;
        insert_valid = 1'b0;
        checkEq("same_cyc_hit", {255'b0, resp_hit}, 256'd1);
        checkEq("same_cyc_old_data", resp_data, mkLine(8'h61));
        checkEq("same_cyc_old_dirty", {255'b0, resp_dirty}, 256'd0);
        doLookup("same_cyc_new", 32'h1000, 1'b1, 1'b1, 8'h62, mkLine(8'h62));

        // Flush: 3 dirty + 1 clean, with wb_ready toggling
        applyReset;
        doInsert(32'h1000, mkLine(8'h81), 1'b1);
        doInsert(32'h2000, mkLine(8'h82), 1'b1);
        doInsert(32'h3000, mkLine(8'h83), 1'b0);
        doInsert(32'h4000, mkLine(8'h84), 1'b1);
        flush_req = 1'b1;
        tick;
        flush_req = 1'b0;
        checkEq("flush_busy_on", {255'b0, flush_busy}, 256'd1);
        checkEq("flush_ins_blocked", {255'b0, insert_ready}, 256'd0);
        doLookup("flush_lookup", 32'h1000, 1'b0, 1'b0, 8'h00, 256'd0);
        nWb = 0;
        for (int c = 0; c < 200; c++) begin
            wb_ready = c[0];
            if (wb_valid && wb_ready) begin
                if (nWb < 3) begin
                    wbA[nWb] = wb_addr;
                    wbD[nWb] = wb_data;
                end
                nWb++;
            end
            if (!flush_busy && !wb_valid)
                break;
            tick;
        end
        wb_ready = 1'b0;
        checkEq("flush_wb_count", 256'(nWb), 256'd3);
        if (nWb >= 3) begin
            checkEq("flush_wb0_addr", {224'b0, wbA[0]}, 256'h1000);
            checkEq("flush_wb1_addr", {224'b0, wbA[1]}, 256'h2000);
            checkEq("flush_wb2_addr", {224'b0, wbA[2]}, 256'h4000);
            checkEq("flush_wb0_data", wbD[0], mkLine(8'h81));
            checkEq("flush_wb2_data", wbD[2], mkLine(8'h84));
        end
        checkEq("flush_busy_off", {255'b0, flush_busy}, 256'd0);
        checkEq("flush_ins_ready", {255'b0, insert_ready}, 256'd1);
        doLookup("flushed1000", 32'h1000, 1'b0, 1'b0, 8'h00, 256'd0);
        doLookup("flushed2000", 32'h2000, 1'b0, 1'b0, 8'h00, 256'd0);
        doLookup("flushed3000", 32'h3000, 1'b0, 1'b0, 8'h00, 256'd0);
        doLookup("flushed4000", 32'h4000, 1'b0, 1'b0, 8'h00, 256'd0);

        // Asynchronous reset while flush is waiting on a writeback
        applyReset;
        doInsert(32'h1000, mkLine(8'h91), 1'b1);
        flush_req = 1'b1;
        tick;
        flush_req = 1'b0;
        tick;
        tick;
        checkEq("wait_wb_valid", {255'b0, wb_valid}, 256'd1);
        checkEq("wait_flush_busy", {255'b0, flush_busy}, 256'd1);
        RST_N = 1'b0;
        #2;
        checkEq("arst_wb_valid", {255'b0, wb_valid}, 256'd0);
        checkEq("arst_flush_busy", {255'b0, flush_busy}, 256'd0);
        checkEq("arst_ins_ready", {255'b0, insert_ready}, 256'd1);
        #2;
        RST_N = 1'b1;
        tick;
        doLookup("arst_miss", 32'h1000, 1'b0, 1'b0, 8'h00, 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/gt_victim_cache.md
# gt_victim_cache

Parametrised fully-associative victim cache between the L1 data cache and the memory interface. Lines evicted from L1 are inserted and looked up on later L1 misses; a hit returns the whole line plus the requested byte and removes it (swap-out). Dirty lines displaced by tree-PLRU replacement, or drained by an explicit flush, leave through a single-entry valid/ready writeback port.

## Interface
- LINE_BITS, 256, line width in bits; power of 2, ≥ 64
- ADDR_W, 32, byte-address width
- WAYS, 4, number of entries; power of 2, 2..16
- Derived: OFF_W = log2(LINE_BITS/8), TAG_W = ADDR_W − OFF_W
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- lookup_valid  in  1  lookup request this cycle
- lookup_addr  in  ADDR_W  byte address to look up
- resp_valid  out  1  lookup response (one cycle after request)
- resp_hit  out  1  line found
- resp_data  out  LINE_BITS  hit line (0 on miss)
- resp_byte  out  8  byte at lookup_addr offset (0 on miss)
- resp_dirty  out  1  dirty flag of hit line
- insert_valid  in  1  L1 eviction offered
- insert_ready  out  1  insert accepted when both high
- insert_addr  in  ADDR_W  address of evicted line (offset ignored)
- insert_data  in  LINE_BITS  evicted line
- insert_dirty  in  1  evicted line is modified
- wb_valid  out  1  writeback line pending
- wb_ready  in  1  memory accepts writeback
- wb_addr  out  ADDR_W  line address, offset bits 0
- wb_data  out  LINE_BITS  writeback line
- flush_req  in  1  pulse: write back all dirty lines, invalidate all
- flush_busy  out  1  flush in progress

## Operation
- Per way: valid, dirty, TAG_W tag, LINE_BITS data. PLRU tree of WAYS−1 bits, node bit 0 = victim on left subtree.
- Reset: all valid/dirty/PLRU bits 0; outputs: insert_ready 1, resp_* 0, wb_valid 0, wb_addr 0, wb_data 0, flush_busy 0. Pending writeback discarded.
- Lookup: tag compare against valid ways only. Hit: resp_data = line, resp_byte = bits [8·off+7 : 8·off] (byte 0 = LSBs), way invalidated, PLRU not touched. Miss: resp_hit 0.
- insert_ready = !wb_valid && state == IDLE.
- Insert target: valid way with same tag (overwrite in place, dirty = old | new, no writeback); else lowest-index invalid way; else PLRU victim. Victim valid & dirty → loaded into wb register (wb_valid 1); clean victim silently dropped.
- Every insert updates PLRU path to point away from written way.
- Same-cycle lookup and insert: both use start-of-cycle state; lookup reports old contents; if both address one way, insert's write wins (way ends valid with new line).
- Flush FSM: IDLE → SCAN on flush_req (ignored outside IDLE). SCAN walks way index 0..WAYS−1, one per cycle; valid & dirty way → load wb register, go WAIT; WAIT → SCAN after wb handshake. After last way: clear all valid/dirty/PLRU, → IDLE. flush_busy = state != IDLE. An in-flight wb at flush_req completes before first SCAN load (SCAN stalls while wb_valid).
- During flush: lookups answered resp_valid 1, resp_hit 0; inserts blocked.

## Timing
- Lookup latency 1: request at edge n → resp_* valid after edge n+1, held one cycle; resp_valid deasserts next cycle unless new request.
- Insert takes effect at accepting edge; lookup in next cycle sees it.
- wb_valid rises the edge after victim insert; holds wb_addr/wb_data stable until wb_valid && wb_ready; drops the following edge.
- Flush length: WAYS + 1 cycles minimum, plus wb stall cycles.

## Test plan
- Reset, insert 0x1000/0x2000/0x3000/0x4000 clean → lookup 0x2005: resp_hit 1 one cycle later, resp_byte = byte 5 of line; repeat lookup 0x2005 → miss.
- Fill 4 ways in order 0..3 with dirty lines, insert 0x5000 → way 0 replaced, wb_valid 1, wb_addr 0x1000; with wb_ready 0, insert_ready stays 0 until accept.
- Lookup hit on way 1 then insert 0x6000 → lands in way 1 (invalid-first), no writeback.
- Insert 0x1000 clean then 0x1000 dirty → single entry, dirty 1, no writeback; lookup returns second data.
- 3 dirty + 1 clean line, flush_req, wb_ready toggling → exactly 3 writebacks in way order, flush_busy drops, all lookups then miss.
- RST_N low during flush WAIT with wb_valid 1 → wb_valid 0, flush_busy 0, insert_ready 1 immediately, all lookups miss.
